pc_sequencer: RTL and testbench

- Fetch-side program-counter sequencer for KGP-RISC.
- Holds the architectural ALU flag register (sign, carry, zero) that branch conditions consume.
- Evaluates branch conditions for the instruction currently in execute and drives the next fetch address to the synchronous instruction memory.
- After every taken jump it squashes the one wrong-path instruction, and it halts on HALT.

---
 rtl/kgp_branch_pkg.sv | 25 ++
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer_branch_cond.sv | 26 ++
 rtl/pc_sequencer.sv | 83 ++++++++
 tb/tb_pc_sequencer.sv | 137 +++++++++++++
 5 files changed

// File: rtl/kgp_branch_pkg.sv
// Shared decode constants for the KGP-RISC fetch sequencer: branch opcodes,
// sequencer state encoding and flag register bit positions.
package kgp_branch_pkg;

    localparam logic [5:0] OP_B    = 6'b000110;
    localparam logic [5:0] OP_BLTZ = 6'b000111;
    localparam logic [5:0] OP_BZ   = 6'b001000;
    localparam logic [5:0] OP_BNZ  = 6'b001001;
    localparam logic [5:0] OP_BR   = 6'b001010;
    localparam logic [5:0] OP_BL   = 6'b001011;
    localparam logic [5:0] OP_BCY  = 6'b001101;
    localparam logic [5:0] OP_BNCY = 6'b001110;
    localparam logic [5:0] OP_HALT = 6'b001111;

    localparam int FLAG_SIGN  = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_ZERO  = 0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Execute-side bundle between the pipeline and the pc sequencer.
// The master drives the presented instruction and ALU flags; the slave returns fetch control.
interface pc_sequencer_if #(parameter int ADDR_W = 32);

    logic              en;
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] rs_val;
    logic              flag_we;
    logic              alu_sign;
    logic              alu_carry;
    logic              alu_zero;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] exec_pc;
    logic              flush;
    logic              link_we;
    logic [ADDR_W-1:0] link_addr;
    logic              halted;
    logic [2:0]        flags;

    modport master (
        output en, opcode, offset, rs_val, flag_we, alu_sign, alu_carry, alu_zero,
        input  pc, exec_pc, flush, link_we, link_addr, halted, flags
    );

    modport slave (
        input  en, opcode, offset, rs_val, flag_we, alu_sign, alu_carry, alu_zero,
        output pc, exec_pc, flush, link_we, link_addr, halted, flags
    );

endinterface

// File: rtl/pc_sequencer_branch_cond.sv
// Branch decode: classifies the presented opcode and resolves its condition
// against the registered flag value.
module branch_cond
    import kgp_branch_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [2:0] flags,
    output logic       is_branch,
    output logic       taken
);

    always_comb begin
        is_branch = 1'b1;
        taken     = 1'b0;
        case (opcode)
            OP_B, OP_BR, OP_BL: taken = 1'b1;
            OP_BLTZ: taken = flags[FLAG_SIGN];
            OP_BZ:   taken = flags[FLAG_ZERO];
            OP_BNZ:  taken = ~flags[FLAG_ZERO];
            OP_BCY:  taken = flags[FLAG_CARRY];
            OP_BNCY: taken = ~flags[FLAG_CARRY];
            default: is_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// KGP-RISC fetch pc sequencer: owns the flag register, resolves branches in
// execute, squashes the single wrong-path slot after a taken jump, and halts.
module pc_sequencer
    import kgp_branch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

    seq_state_t        state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] exec_pc_q;
    logic [2:0]        flags_q;
    logic              is_branch;
    logic              cond_true;
    logic              run_go;
    logic              take;
    logic [ADDR_W-1:0] seq_base;
    logic [ADDR_W-1:0] target;

    branch_cond u_cond (
        .opcode    (bus.opcode),
        .flags     (flags_q),
        .is_branch (is_branch),
        .taken     (cond_true)
    );

    // Relative targets and the BL return address share exec_pc + 4.
    assign run_go   = (state == ST_RUN) && bus.en;
    assign take     = is_branch && cond_true;
    assign seq_base = exec_pc_q + WORD;
    assign target   = (bus.opcode == OP_BR) ? bus.rs_val : seq_base + bus.offset;

    assign bus.pc        = pc_q;
    assign bus.exec_pc   = exec_pc_q;
    assign bus.flags     = flags_q;
    assign bus.flush     = (state == ST_FLUSH);
    assign bus.halted    = (state == ST_HALT);
    assign bus.link_we   = rst && run_go && (bus.opcode == OP_BL);
    assign bus.link_addr = seq_base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            pc_q      <= RESET_PC;
            exec_pc_q <= RESET_PC;
            flags_q   <= 3'b000;
        end else begin
            case (state)
                ST_RUN: if (bus.en) begin
                    // Flags update even alongside a branch; the branch saw the old value.
                    if (bus.flag_we)
                        flags_q <= {bus.alu_sign, bus.alu_carry, bus.alu_zero};
                    if (bus.opcode == OP_HALT) begin
                        state <= ST_HALT;
                    end else begin
                        exec_pc_q <= pc_q;
                        if (take) begin
                            pc_q  <= target;
                            state <= ST_FLUSH;
                        end else begin
                            pc_q <= pc_q + WORD;
                        end
                    end
                end
                ST_FLUSH: if (bus.en) begin
                    exec_pc_q <= pc_q;
                    pc_q      <= pc_q + WORD;
                    state     <= ST_RUN;
                end
                ST_HALT: ;
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed pc/exec_pc/flag/flush traces.
module tb_pc_sequencer;
    import kgp_branch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [5:0] op, input logic [31:0] off,
                         input logic [31:0] rs, input logic fwe, input logic [2:0] alu);
        bus.en        = e;
        bus.opcode    = op;
        bus.offset    = off;
        bus.rs_val    = rs;
        bus.flag_we   = fwe;
        bus.alu_sign  = alu[2];
        bus.alu_carry = alu[1];
        bus.alu_zero  = alu[0];
    endtask

    task automatic chk_state(input string tag, input logic [31:0] epc, input logic [31:0] eexec,
                             input logic efl, input logic [2:0] eflags);
        chk({tag, ".pc"}, bus.pc, epc);
        chk({tag, ".exec_pc"}, bus.exec_pc, eexec);
        chk({tag, ".flush"}, 32'(bus.flush), 32'(efl));
        chk({tag, ".flags"}, 32'(bus.flags), 32'(eflags));
    endtask

    initial begin
        drive(1'b1, 6'b000000, 32'h0, 32'h0, 1'b0, 3'b000);
        #2;
        chk_state("reset", 32'h0, 32'h0, 1'b0, 3'b000);
        chk("reset.halted", 32'(bus.halted), 32'h0);
        chk("reset.link_we", 32'(bus.link_we), 32'h0);
        #10 rst = 1'b1;

        // Sequential fetch; the third slot is an ALU op setting zero.
        step(); chk_state("seq1", 32'h4, 32'h0, 1'b0, 3'b000);
        step(); chk_state("seq2", 32'h8, 32'h4, 1'b0, 3'b000);
        drive(1'b1, 6'b000000, 32'h0, 32'h0, 1'b1, 3'b001);
        step(); chk_state("seq3", 32'hC, 32'h8, 1'b0, 3'b001);

        // BZ at exec_pc 0x8, offset 0x10 -> 0x1C
        drive(1'b1, OP_BZ, 32'h10, 32'h0, 1'b0, 3'b000);
        step(); chk_state("bz", 32'h1C, 32'hC, 1'b1, 3'b001);
        step(); chk_state("bz.tgt", 32'h20, 32'h1C, 1'b0, 3'b001);

        // BLTZ with same-cycle sign update: old sign=0, so falls through
        drive(1'b1, OP_BLTZ, 32'h40, 32'h0, 1'b1, 3'b100);
        step(); chk_state("bltz", 32'h24, 32'h20, 1'b0, 3'b100);

        // BL at exec_pc 0x20, offset -8
        drive(1'b1, OP_BL, 32'hFFFF_FFF8, 32'h0, 1'b0, 3'b000);
        #1;
        chk("bl.link_we", 32'(bus.link_we), 32'h1);
        chk("bl.link_addr", bus.link_addr, 32'h24);
        step(); chk_state("bl", 32'h1C, 32'h24, 1'b1, 3'b100);
        chk("bl.flush_link_we", 32'(bus.link_we), 32'h0);
        step(); chk_state("bl.tgt", 32'h20, 32'h1C, 1'b0, 3'b100);

        drive(1'b1, OP_BR, 32'h0, 32'h24, 1'b0, 3'b000);
        step(); chk_state("br", 32'h24, 32'h20, 1'b1, 3'b100);
        drive(1'b1, 6'b000000, 32'h0, 32'h0, 1'b0, 3'b000);
        step(); chk_state("br.tgt", 32'h28, 32'h24, 1'b0, 3'b100);

        // Set carry, then BCY at exec_pc 0x28, offset 0x40 -> 0x6C
        drive(1'b1, 6'b000001, 32'h0, 32'h0, 1'b1, 3'b010);
        step(); chk_state("alu.cy", 32'h2C, 32'h28, 1'b0, 3'b010);
        drive(1'b1, OP_BCY, 32'h40, 32'h0, 1'b0, 3'b000);
        step(); chk_state("bcy", 32'h6C, 32'h2C, 1'b1, 3'b010);

        // Stall during the squash slot; BNCY and flag_we must be ignored
        drive(1'b0, OP_BNCY, 32'h100, 32'h0, 1'b1, 3'b101);
        step(); chk_state("stall1", 32'h6C, 32'h2C, 1'b1, 3'b010);
        step(); chk_state("stall2", 32'h6C, 32'h2C, 1'b1, 3'b010);
        drive(1'b1, OP_BNCY, 32'h100, 32'h0, 1'b1, 3'b101);
        step(); chk_state("flush.exit", 32'h70, 32'h6C, 1'b0, 3'b010);

        // Stall in RUN holds state
        drive(1'b0, OP_B, 32'h100, 32'h0, 1'b1, 3'b111);
        step(); chk_state("run.stall", 32'h70, 32'h6C, 1'b0, 3'b010);

        drive(1'b1, OP_HALT, 32'h0, 32'h0, 1'b0, 3'b000);
        step(); chk_state("halt", 32'h70, 32'h6C, 1'b0, 3'b010);
        chk("halt.halted", 32'(bus.halted), 32'h1);
        drive(1'b1, OP_B, 32'h100, 32'h0, 1'b1, 3'b111);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt.pc", bus.pc, 32'h70);
        end
        chk("halt.flags", 32'(bus.flags), 32'h2);
        chk("halt.halted2", 32'(bus.halted), 32'h1);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b0;
        #1;
        chk_state("areset", 32'h0, 32'h0, 1'b0, 3'b000);
        chk("areset.halted", 32'(bus.halted), 32'h0);
        chk("areset.link_we", 32'(bus.link_we), 32'h0);
        #3 rst = 1'b1;

        // Wrap: BR to 0xFFFFFFFC, then pc+4 wraps, then relative target wraps
        drive(1'b1, OP_BR, 32'h0, 32'hFFFF_FFFC, 1'b0, 3'b000);
        step(); chk_state("wrap.br", 32'hFFFF_FFFC, 32'h0, 1'b1, 3'b000);
        step(); chk_state("wrap.pc4", 32'h0, 32'hFFFF_FFFC, 1'b0, 3'b000);
        drive(1'b1, OP_B, 32'h8, 32'h0, 1'b0, 3'b000);
        step(); chk_state("wrap.tgt", 32'h8, 32'h0, 1'b1, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
